// File: rtl/inv_mix_columns_engine.sv
// Sequential AES (Inv)MixColumns engine: COLS_PER_CYCLE columns per BUSY cycle.
// Define MIXCOL_FWD_EN to add forward MixColumns selected by mode_inv=0.
module inv_mix_columns_engine #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    input  logic         mode_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    localparam int unsigned NumBeats = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  LastBeat = 2'(NumBeats - 1);

    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
        $error("COLS_PER_CYCLE must be 1, 2 or 4");
    end

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    function automatic logic [31:0] inv_col(input logic [31:0] col);
        logic [7:0] b [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            b[i]  = col[8*i +: 8];
            x2[i] = xtime(b[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
        end
        for (int r = 0; r < 4; r++) begin
            // 0E, 0B, 0D, 09 applied to b[r], b[r+1], b[r+2], b[r+3]
            res[8*r +: 8] = (x8[r] ^ x4[r] ^ x2[r])
                          ^ (x8[(r+1)%4] ^ x2[(r+1)%4] ^ b[(r+1)%4])
                          ^ (x8[(r+2)%4] ^ x4[(r+2)%4] ^ b[(r+2)%4])
                          ^ (x8[(r+3)%4] ^ b[(r+3)%4]);
        end
        return res;
    endfunction

`ifdef MIXCOL_FWD_EN
    function automatic logic [31:0] fwd_col(input logic [31:0] col);
        logic [7:0] b [4];
        logic [7:0] x2 [4];
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 4; i++) begin
            b[i]  = col[8*i +: 8];
            x2[i] = xtime(b[i]);
        end
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = x2[r] ^ (x2[(r+1)%4] ^ b[(r+1)%4]) ^ b[(r+2)%4] ^ b[(r+3)%4];
        end
        return res;
    endfunction
`endif

    state_e       state_q, state_d;
    logic [1:0]   beat_q, beat_d;
    logic [127:0] src_q, src_d;
    logic [127:0] res_q, res_d;
    logic         in_ready_q, out_valid_q, busy_q;
    logic [1:0]   col_idx;
    logic [31:0]  col_in;
    logic [31:0]  col_out;

`ifdef MIXCOL_FWD_EN
    logic mode_q, mode_d;
`else
    logic unused_mode_inv;
    assign unused_mode_inv = mode_inv;
`endif

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        src_d   = src_q;
        res_d   = res_q;
        col_idx = '0;
        col_in  = '0;
        col_out = '0;
`ifdef MIXCOL_FWD_EN
        mode_d  = mode_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    state_d = StBusy;
                    src_d   = state_in;
                    beat_d  = '0;
`ifdef MIXCOL_FWD_EN
                    mode_d  = mode_inv;
`endif
                end
            end
            StBusy: begin
                for (int unsigned p = 0; p < COLS_PER_CYCLE; p++) begin
                    col_idx = 2'((32'(beat_q) * COLS_PER_CYCLE) + p);
                    col_in  = src_q[32*col_idx +: 32];
`ifdef MIXCOL_FWD_EN
                    col_out = mode_q ? inv_col(col_in) : fwd_col(col_in);
`else
                    col_out = inv_col(col_in);
`endif
                    res_d[32*col_idx +: 32] = col_out;
                end
                if (beat_q == LastBeat) begin
                    state_d = StDone;
                    beat_d  = '0;
                end else begin
                    beat_d  = beat_q + 2'd1;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            beat_q      <= '0;
            src_q       <= '0;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
`ifdef MIXCOL_FWD_EN
            mode_q      <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            src_q       <= src_d;
            res_q       <= res_d;
            // Handshake flags come straight from flops decoded off the next state
            in_ready_q  <= (state_d == StIdle);
            out_valid_q <= (state_d == StDone);
            busy_q      <= (state_d != StIdle);
`ifdef MIXCOL_FWD_EN
            mode_q      <= mode_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = res_q;

endmodule

// File: tb/tb_inv_mix_columns_engine.sv
// Directed and random checks of inv_mix_columns_engine for P = 1, 2 and 4 in parallel.
module tb_inv_mix_columns_engine;

`ifdef MIXCOL_FWD_EN
    localparam bit FwdEn = 1'b1;
`else
    localparam bit FwdEn = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   in_valid = '0;
    logic [2:0]   mode_inv = '0;
    logic [2:0]   out_ready = '0;
    logic [127:0] state_in [3];
    wire  [2:0]   in_ready;
    wire  [2:0]   out_valid;
    wire  [2:0]   busy;
    wire  [127:0] state_out [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_engine #(
            .COLS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .mode_inv  (mode_inv[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
            .busy      (busy[g])
        );
    end

    typedef struct {
        logic [127:0] st;
        logic         md;
        logic [127:0] exp_fwd;
        logic [127:0] exp_inv;
        bit           inv_from_model;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] coef(input bit inv, input int k);
        case (k)
            0:       return inv ? 8'h0E : 8'h02;
            1:       return inv ? 8'h0B : 8'h03;
            2:       return inv ? 8'h0D : 8'h01;
            default: return inv ? 8'h09 : 8'h01;
        endcase
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input bit inv);
        logic [127:0] o = '0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gmul(coef(inv, k), st[32*c + 8*((r+k)%4) +: 8]);
                end
                o[32*c + 8*r +: 8] = acc;
            end
        end
        return o;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] vec_exp(input vec_t v);
        if (!v.md && FwdEn) return v.exp_fwd;
        if (v.inv_from_model) return model(v.st, 1'b1);
        return v.exp_inv;
    endfunction

    task automatic run_vec(input int k, input logic [127:0] st, input logic md,
                           input logic [127:0] exp, input string nm);
        int cyc = 0;
        chk($sformatf("%s/p%0d ready", nm, k), 128'(in_ready[k]), 128'd1);
        in_valid[k] = 1'b1;
        state_in[k] = st;
        mode_inv[k] = md;
        tick();
        in_valid[k] = 1'b0;
        state_in[k] = ~st;
        while (!out_valid[k] && cyc < 20) begin
            mode_inv[k] = ~mode_inv[k];
            tick();
            cyc++;
        end
        chk($sformatf("%s/p%0d latency", nm, k), 128'(cyc), 128'(4 >> k));
        chk($sformatf("%s/p%0d data", nm, k), state_out[k], exp);
        chk($sformatf("%s/p%0d ready_done", nm, k), 128'(in_ready[k]), 128'd0);
        chk($sformatf("%s/p%0d busy_done", nm, k), 128'(busy[k]), 128'd1);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        chk($sformatf("%s/p%0d valid_after", nm, k), 128'(out_valid[k]), 128'd0);
        chk($sformatf("%s/p%0d ready_after", nm, k), 128'(in_ready[k]), 128'd1);
        chk($sformatf("%s/p%0d busy_after", nm, k), 128'(busy[k]), 128'd0);
    endtask

    task automatic run_random(input int k, input int n);
        logic [127:0] q [$];
        int           sent = 0;
        int           got = 0;
        int           cyc = 0;
        bit           acc;
        bit           hs;
        logic [127:0] hs_data;
        logic [127:0] cur;
        logic         cur_m;
        cur   = {$urandom, $urandom, $urandom, $urandom};
        cur_m = 1'($urandom_range(0, 1));
        while (got < n && cyc < 2000) begin
            in_valid[k]  = (sent < n);
            state_in[k]  = cur;
            mode_inv[k]  = cur_m;
            out_ready[k] = 1'($urandom_range(0, 1));
            chk($sformatf("rand/p%0d ready_valid_excl", k),
                128'(in_ready[k] && out_valid[k]), 128'd0);
            acc     = in_valid[k] && in_ready[k];
            hs      = out_valid[k] && out_ready[k];
            hs_data = state_out[k];
            if (acc) q.push_back(model(cur, cur_m || !FwdEn));
            tick();
            cyc++;
            if (acc) begin
                sent++;
                cur   = {$urandom, $urandom, $urandom, $urandom};
                cur_m = 1'($urandom_range(0, 1));
            end
            if (hs) begin
                if (q.size() == 0) begin
                    chk($sformatf("rand/p%0d duplicate", k), 128'(got), 128'(n + 1));
                end else begin
                    chk($sformatf("rand/p%0d item%0d", k, got), hs_data, q.pop_front());
                end
                got++;
            end
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        chk($sformatf("rand/p%0d count", k), 128'(got), 128'(n));
        chk($sformatf("rand/p%0d leftover", k), 128'(q.size()), 128'd0);
    endtask

    initial begin
        logic [127:0] e;
        int           n;

        vecs[0] = '{{32'h9D58DC9F, 32'h9D58DC9F, 32'h9D58DC9F, 32'hBCA14D8E}, 1'b1,
                    {32'h5C220AF2, 32'h5C220AF2, 32'h5C220AF2, 32'h455313DB},
                    {32'h5C220AF2, 32'h5C220AF2, 32'h5C220AF2, 32'h455313DB}, 1'b0};
        vecs[1] = '{{32'h01010101, 32'hC6C6C6C6, 32'h01010101, 32'hC6C6C6C6}, 1'b1,
                    {32'h01010101, 32'hC6C6C6C6, 32'h01010101, 32'hC6C6C6C6},
                    {32'h01010101, 32'hC6C6C6C6, 32'h01010101, 32'hC6C6C6C6}, 1'b0};
        vecs[2] = '{{32'h00000001, 96'h0}, 1'b1,
                    {32'h0B0D090E, 96'h0}, {32'h0B0D090E, 96'h0}, 1'b0};
        vecs[3] = '{{96'h0, 32'h00000001}, 1'b0,
                    {96'h0, 32'h03010102}, {96'h0, 32'h0B0D090E}, 1'b0};
        vecs[4] = '{{32'hC6C6C6C6, 32'h01010101, 32'h5C220AF2, 32'h455313DB}, 1'b0,
                    {32'hC6C6C6C6, 32'h01010101, 32'h9D58DC9F, 32'hBCA14D8E},
                    128'h0, 1'b1};
        vecs[5] = '{128'h0, 1'b0, 128'h0, 128'h0, 1'b0};
        vecs[6] = '{{128{1'b1}}, 1'b1, {128{1'b1}}, {128{1'b1}}, 1'b0};

        for (int k = 0; k < 3; k++) state_in[k] = '0;
        repeat (3) tick();
        rst = 1'b0;

        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset/p%0d in_ready", k), 128'(in_ready[k]), 128'd1);
            chk($sformatf("reset/p%0d out_valid", k), 128'(out_valid[k]), 128'd0);
            chk($sformatf("reset/p%0d busy", k), 128'(busy[k]), 128'd0);
            chk($sformatf("reset/p%0d state_out", k), state_out[k], 128'h0);
        end

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 3; k++) begin
                run_vec(k, vecs[v].st, vecs[v].md, vec_exp(vecs[v]), $sformatf("vec%0d", v));
            end
        end

        // Backpressure on P=2 with a competing input held high
        e = vec_exp(vecs[0]);
        in_valid[1] = 1'b1;
        state_in[1] = vecs[0].st;
        mode_inv[1] = 1'b1;
        tick();
        in_valid[1] = 1'b0;
        n = 0;
        while (!out_valid[1] && n < 20) begin
            tick();
            n++;
        end
        chk("bp latency", 128'(n), 128'd2);
        for (int i = 0; i < 10; i++) begin
            in_valid[1] = 1'b1;
            state_in[1] = vecs[1].st;
            tick();
            chk($sformatf("bp hold%0d data", i), state_out[1], e);
            chk($sformatf("bp hold%0d in_ready", i), 128'(in_ready[1]), 128'd0);
            chk($sformatf("bp hold%0d out_valid", i), 128'(out_valid[1]), 128'd1);
        end
        in_valid[1]  = 1'b0;
        out_ready[1] = 1'b1;
        tick();
        out_ready[1] = 1'b0;
        chk("bp release in_ready", 128'(in_ready[1]), 128'd1);
        chk("bp release out_valid", 128'(out_valid[1]), 128'd0);
        chk("bp release busy", 128'(busy[1]), 128'd0);
        chk("bp release data", state_out[1], e);

        // Reset on the second BUSY cycle of P=1
        in_valid[0] = 1'b1;
        state_in[0] = vecs[0].st;
        mode_inv[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst mid in_ready", 128'(in_ready[0]), 128'd1);
        chk("rst mid out_valid", 128'(out_valid[0]), 128'd0);
        chk("rst mid busy", 128'(busy[0]), 128'd0);
        chk("rst mid state_out", state_out[0], 128'h0);
        run_vec(0, vecs[6].st, 1'b1, vec_exp(vecs[6]), "after_rst");

        for (int k = 0; k < 3; k++) run_random(k, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/inv_mix_columns_engine.md
# inv_mix_columns_engine

Sequential, parametrised MixColumns/InvMixColumns engine for the AES datapath. It accepts a full 128-bit state over a valid/ready handshake and processes COLS_PER_CYCLE columns per clock. It returns the transformed state over a second valid/ready handshake. It generalises the single-row, combinational inverse-row multiplier to whole-state operation with a selectable number of columns per cycle, optional forward mode, and flow control.

## Interface
- COLS_PER_CYCLE, default 1: columns processed per BUSY cycle. Legal values are 1, 2 or 4; any other value is an elaboration error.
- clk  input  1  clock, rising-edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  state_in and mode_inv are valid.
- in_ready  output  1  engine can accept a state.
- state_in  input  128  input state. Column c occupies bits [32c+31:32c]. Row r of column c occupies bits [32c+8r+7:32c+8r].
- mode_inv  input  1  1 selects InvMixColumns; 0 selects MixColumns (see Configuration).
- out_valid  output  1  state_out is valid.
- out_ready  input  1  downstream accepts state_out.
- state_out  output  128  result, using the same byte layout as state_in.
- busy  output  1  high in the BUSY and DONE states.

## Operation
- FSM states:
  - IDLE: in_ready=1.
  - BUSY: computing.
  - DONE: out_valid=1, holding the result.
- IDLE -> BUSY: on in_valid && in_ready. On that edge the engine captures state_in into the source register, captures mode_inv into the mode register, and clears the beat counter.
- BUSY: each cycle computes columns beat*P .. beat*P+P-1, where P = COLS_PER_CYCLE. The results are written into the same column positions of the result register, and the beat counter increments.
- BUSY -> DONE: on the edge that writes the last beat (beat == 4/P-1).
- DONE -> IDLE: on out_valid && out_ready. state_out holds its value until the next result overwrites it.
- Per-column arithmetic in GF(2^8), reduction polynomial 0x11B. For output row r, with input bytes b0..b3:
  - Inverse: coefficient for b((r+k) mod 4) is [0x0E, 0x0B, 0x0D, 0x09][k].
  - Forward: coefficients are [0x02, 0x03, 0x01, 0x01][k].
  - Row 1 inverse expands to 09·b0 ^ 0E·b1 ^ 0B·b2 ^ 0D·b3.
- Each column slice is strictly 8 bits per byte. No byte straddles a slice.
- in_valid while not in IDLE is ignored. There is no queueing, and the source is not overwritten.
- mode_inv changes while busy have no effect; the captured mode is used for the whole state.
- out_ready while not in DONE is ignored.
- rst asserted in any state, including mid-BUSY: on that edge the FSM goes to IDLE, the beat counter clears, and partial results are discarded.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - busy=0
  - state_out=0
  - beat counter=0
- All outputs are registered. There is no combinational path from in_valid or out_ready to any output.
- Latency: for acceptance at edge T, out_valid rises after edge T+4/P. That is 4, 2 or 1 cycles for P = 1, 2, 4.
- out_valid stays high until the out_ready handshake edge. in_ready is 1 in the cycle after that edge.
- Minimum issue interval: 4/P + 2 cycles (accept, compute beats, handshake, return to IDLE).
- in_ready and out_valid are never high together.

## Configuration
- MIXCOL_FWD_EN defined:
  - Forward multipliers are instantiated.
  - mode_inv=0 selects MixColumns; mode_inv=1 selects InvMixColumns.
- MIXCOL_FWD_EN undefined:
  - Forward logic is absent.
  - Every state is InvMixColumns regardless of mode_inv.
  - mode_inv is still present as a port and ignored.

## Test plan
- Inverse with P=1, column 0 = 32'hBCA1_4D8E, other columns 32'h9D58_DC9F: state_out columns are 32'h4553_13DB and 32'h5C22_0AF2; out_valid rises 4 cycles after accept.
- Forward (MIXCOL_FWD_EN defined, mode_inv=0), P=4, columns 32'h4553_13DB, 32'h5C22_0AF2, 32'h0101_0101, 32'hC6C6_C6C6: outputs are 32'hBCA1_4D8E, 32'h9D58_DC9F, 32'h0101_0101, 32'hC6C6_C6C6; latency 1 cycle. Without the macro, the same stimulus is treated as inverse.
- Backpressure, P=2: hold out_ready=0 for 10 cycles after out_valid. state_out must be stable, in_ready=0, and a new in_valid with a different state must be ignored. Raise out_ready; the first result is delivered and in_ready=1 on the next cycle.
- Reset mid-BUSY, P=1: assert rst on the 2nd BUSY cycle. Next cycle in_ready=1, out_valid=0, busy=0, state_out=0. A fresh state then completes correctly in 4 cycles.
- mode_inv is toggled every cycle during BUSY: the result matches the mode captured at accept.
- Back-to-back random states with random out_ready, checked against a software AES (Inv)MixColumns model for P=1, 2 and 4: no dropped or duplicated results.
